rv_icache_multi_stage: RTL

- Parametrised successor to the single-outstanding icache fetch stage.
- Sits between the warp scheduler's ifetch request stream and the icache.
- Tracks up to NUM_SLOTS outstanding icache requests, across any warps, in a slot table. The icache tag carries {uuid, slot}.
- Accepts out-of-order icache responses and delivers them downstream in arrival order through a slot-index FIFO. Never back-pressures the icache response port.

---
 rtl/rv_icache_multi_stage_pkg.sv | 15 +
 rtl/rv_icache_multi_stage_index_fifo.sv | 39 +++
 rtl/rv_icache_multi_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/rv_icache_multi_stage_pkg.sv
// rv_icache_multi_stage_pkg: shared sizing constants and slot state encodings
package rv_icache_multi_stage_pkg;
    localparam int NUM_WARPS   = 4;
    localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int NUM_THREADS = 4;
    localparam int UUID_BITS   = 8;
    localparam int NUM_SLOTS   = 4;
    localparam int SLOT_BITS   = $clog2(NUM_SLOTS);
    localparam int TAG_WIDTH   = UUID_BITS + SLOT_BITS;
    typedef enum logic [1:0] {
        SLOT_FREE = 2'b00,
        SLOT_WAIT = 2'b10,
        SLOT_DONE = 2'b11
    } slot_state_e;
endpackage

// File: rtl/rv_icache_multi_stage_index_fifo.sv
// rv_index_fifo: small FIFO of slot indices with registered count
module rv_index_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= wr_ptr + AW'(do_push);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/rv_icache_multi_stage.sv
// rv_icache_multi_stage: multi-outstanding icache fetch stage with slot table and in-arrival-order delivery
module rv_icache_multi_stage #(
    parameter int CORE_ID     = 0,
    parameter int NUM_WARPS   = rv_icache_multi_stage_pkg::NUM_WARPS,
    parameter int NW_BITS     = rv_icache_multi_stage_pkg::NW_BITS,
    parameter int NUM_THREADS = rv_icache_multi_stage_pkg::NUM_THREADS,
    parameter int UUID_BITS   = rv_icache_multi_stage_pkg::UUID_BITS,
    parameter int NUM_SLOTS   = rv_icache_multi_stage_pkg::NUM_SLOTS,
    parameter int SLOT_BITS   = rv_icache_multi_stage_pkg::SLOT_BITS,
    parameter int TAG_WIDTH   = UUID_BITS + SLOT_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ifetch_req_if_valid,
    input  logic [UUID_BITS-1:0]   ifetch_req_if_uuid,
    input  logic [NUM_THREADS-1:0] ifetch_req_if_tmask,
    input  logic [NW_BITS-1:0]     ifetch_req_if_wid,
    input  logic [31:0]            ifetch_req_if_PC,
    output logic                   ifetch_req_if_ready,
    output logic                   icache_req_if_valid,
    output logic [29:0]            icache_req_if_addr,
    output logic [TAG_WIDTH-1:0]   icache_req_if_tag,
    input  logic                   icache_req_if_ready,
    input  logic                   icache_rsp_if_valid,
    input  logic [31:0]            icache_rsp_if_data,
    input  logic [TAG_WIDTH-1:0]   icache_rsp_if_tag,
    output logic                   icache_rsp_if_ready,
    output logic                   ifetch_rsp_if_valid,
    output logic [UUID_BITS-1:0]   ifetch_rsp_if_uuid,
    output logic [NUM_THREADS-1:0] ifetch_rsp_if_tmask,
    output logic [NW_BITS-1:0]     ifetch_rsp_if_wid,
    output logic [31:0]            ifetch_rsp_if_PC,
    output logic [31:0]            ifetch_rsp_if_data,
    input  logic                   ifetch_rsp_if_ready,
    output logic [NUM_WARPS-1:0]   pending_warps,
    output logic                   tag_err
);
    import rv_icache_multi_stage_pkg::*;
    slot_state_e            st_q [NUM_SLOTS];
    slot_state_e            st_n [NUM_SLOTS];
    logic [31:0]            pc_q    [NUM_SLOTS];
    logic [31:0]            data_q  [NUM_SLOTS];
    logic [NUM_THREADS-1:0] tmask_q [NUM_SLOTS];
    logic [NW_BITS-1:0]     wid_q   [NUM_SLOTS];
    logic [UUID_BITS-1:0]   uuid_q  [NUM_SLOTS];
    logic                   slot_avail, req_fire, rsp_ok, pop, fifo_empty, fifo_full;
    logic [SLOT_BITS-1:0]   alloc_slot, rsp_slot, head;
    logic [NUM_WARPS-1:0]   pending_n;
    assign rsp_slot            = icache_rsp_if_tag[SLOT_BITS-1:0];
    assign icache_rsp_if_ready = reset;
    assign rsp_ok              = reset & icache_rsp_if_valid & (st_q[rsp_slot] == SLOT_WAIT);
    assign icache_req_if_valid = ifetch_req_if_valid & slot_avail;
    assign ifetch_req_if_ready = icache_req_if_ready & slot_avail;
    assign req_fire            = ifetch_req_if_valid & ifetch_req_if_ready;
    assign icache_req_if_addr  = ifetch_req_if_PC[31:2];
    assign icache_req_if_tag   = {ifetch_req_if_uuid, alloc_slot};
    assign ifetch_rsp_if_valid = reset & ~fifo_empty;
    assign pop                 = ifetch_rsp_if_valid & ifetch_rsp_if_ready;
    assign ifetch_rsp_if_uuid  = uuid_q[head];
    assign ifetch_rsp_if_tmask = tmask_q[head];
    assign ifetch_rsp_if_wid   = wid_q[head];
    assign ifetch_rsp_if_PC    = pc_q[head];
    assign ifetch_rsp_if_data  = data_q[head];
    // descending scan so the lowest-index free slot wins
    always_comb begin
        slot_avail = 1'b0;
        alloc_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (st_q[i] == SLOT_FREE) begin
                slot_avail = 1'b1;
                alloc_slot = SLOT_BITS'(i);
            end
    end
    always_comb begin
        st_n      = st_q;
        pending_n = '0;
        if (pop) st_n[head] = SLOT_FREE;
        if (rsp_ok) st_n[rsp_slot] = SLOT_DONE;
        if (req_fire) st_n[alloc_slot] = SLOT_WAIT;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (st_n[i] != SLOT_FREE)
                pending_n = pending_n | (NUM_WARPS'(1) << ((req_fire && alloc_slot == SLOT_BITS'(i)) ? ifetch_req_if_wid : wid_q[i]));
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) st_q[i] <= SLOT_FREE;
            pending_warps <= '0;
            tag_err       <= 1'b0;
        end else begin
            st_q          <= st_n;
            pending_warps <= pending_n;
            tag_err       <= tag_err | (icache_rsp_if_valid & ~rsp_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_q[alloc_slot]    <= ifetch_req_if_PC;
            tmask_q[alloc_slot] <= ifetch_req_if_tmask;
            wid_q[alloc_slot]   <= ifetch_req_if_wid;
            uuid_q[alloc_slot]  <= ifetch_req_if_uuid;
        end
        if (rsp_ok) data_q[rsp_slot] <= icache_rsp_if_data;
    end
    rv_index_fifo #(.DEPTH(NUM_SLOTS), .WIDTH(SLOT_BITS)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_ok),
        .pop   (pop),
        .din   (rsp_slot),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );
endmodule
